stall_ctrl: RTL

STALL_CTRL -- requirements
Module: stall_ctrl

---
 rtl/stall_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stall_ctrl
//  Description : Hazard/stall unit for a 5-stage MIPS subset pipeline.
//                Tuse/Tnew data-hazard stalls plus a multiply/divide busy counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module stall_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_d,
    input  logic [31:0] instr_e,
    input  logic [31:0] instr_m,
    output logic        pc_en,
    output logic        d_en,
    output logic        e_clr,
    output logic        md_busy,
    output logic        stall
);

    localparam logic [3:0] MUL_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES = 4'd10;

    typedef enum logic [3:0] {
        K_NONE, K_ALU, K_SLL, K_JR, K_MUL, K_DIV, K_MFHL, K_MTHL,
        K_ORI,  K_LUI, K_LW,  K_SW, K_BEQ, K_JAL
    } kind_t;

    function automatic kind_t classify(input logic [31:0] instr);
        kind_t k;
        k = K_NONE;
        if (instr != 32'd0) begin
            case (instr[31:26])
                6'h00: begin
                    case (instr[5:0])
                        6'h21, 6'h23, 6'h24, 6'h25, 6'h2a: k = K_ALU;
                        6'h00:                             k = K_SLL;
                        6'h08:                             k = K_JR;
                        6'h18, 6'h19:                      k = K_MUL;
                        6'h1a, 6'h1b:                      k = K_DIV;
                        6'h10, 6'h12:                      k = K_MFHL;
                        6'h11, 6'h13:                      k = K_MTHL;
                        default:                           k = K_NONE;
                    endcase
                end
                6'h0d:   k = K_ORI;
                6'h0f:   k = K_LUI;
                6'h23:   k = K_LW;
                6'h2b:   k = K_SW;
                6'h04:   k = K_BEQ;
                6'h03:   k = K_JAL;
                default: k = K_NONE;
            endcase
        end
        return k;
    endfunction

    // A non-writer reports destination $0, which can never cause a stall.
    function automatic logic [4:0] dest_of(input kind_t k, input logic [31:0] instr);
        logic [4:0] d;
        d = 5'd0;
        case (k)
            K_ALU, K_SLL, K_MFHL: d = instr[15:11];
            K_ORI, K_LUI, K_LW:   d = instr[20:16];
            K_JAL:                d = 5'd31;
            default:              d = 5'd0;
        endcase
        return d;
    endfunction

    function automatic logic hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] e_dst,
        input logic [1:0] e_tnew,
        input logic [4:0] m_dst,
        input logic [1:0] m_tnew
    );
        return (src != 5'd0) &&
               (((src == e_dst) && (e_tnew > tuse)) ||
                ((src == m_dst) && (m_tnew > tuse)));
    endfunction

    kind_t      kind_d;
    kind_t      kind_e;
    kind_t      kind_m;
    logic       rs_used;
    logic       rt_used;
    logic [1:0] rs_tuse;
    logic [1:0] rt_tuse;
    logic [4:0] e_dst;
    logic [4:0] m_dst;
    logic [1:0] e_tnew;
    logic [1:0] m_tnew;
    logic       data_stall;
    logic       md_stall;
    logic       md_start;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    assign kind_d = classify(instr_d);
    assign kind_e = classify(instr_e);
    assign kind_m = classify(instr_m);

    always_comb begin
        rs_used = 1'b0;
        rt_used = 1'b0;
        rs_tuse = 2'd1;
        rt_tuse = 2'd1;
        case (kind_d)
            K_ALU, K_MUL, K_DIV: begin
                rs_used = 1'b1;
                rt_used = 1'b1;
            end
            K_SLL:               rt_used = 1'b1;
            K_ORI, K_LW, K_MTHL: rs_used = 1'b1;
            K_SW: begin
                rs_used = 1'b1;
                rt_used = 1'b1;
                rt_tuse = 2'd2;
            end
            K_JR: begin
                rs_used = 1'b1;
                rs_tuse = 2'd0;
            end
            K_BEQ: begin
                rs_used = 1'b1;
                rt_used = 1'b1;
                rs_tuse = 2'd0;
                rt_tuse = 2'd0;
            end
            default: ;
        endcase
    end

    always_comb begin
        e_tnew = 2'd0;
        case (kind_e)
            K_LW:                                e_tnew = 2'd2;
            K_ALU, K_SLL, K_ORI, K_LUI, K_MFHL:  e_tnew = 2'd1;
            default:                             e_tnew = 2'd0;
        endcase
    end

    assign m_tnew = {1'b0, kind_m == K_LW};
    assign e_dst  = dest_of(kind_e, instr_e);
    assign m_dst  = dest_of(kind_m, instr_m);

    assign data_stall =
        (rs_used && hazard(instr_d[25:21], rs_tuse, e_dst, e_tnew, m_dst, m_tnew)) ||
        (rt_used && hazard(instr_d[20:16], rt_tuse, e_dst, e_tnew, m_dst, m_tnew));

    assign md_start = (kind_e == K_MUL) || (kind_e == K_DIV);
    assign md_busy  = (cnt_q != 4'd0);
    assign md_stall = ((kind_d == K_MUL) || (kind_d == K_DIV) ||
                       (kind_d == K_MFHL) || (kind_d == K_MTHL)) &&
                      (md_busy || md_start);

    // A start in E reloads the counter even if a previous count is still running.
    always_comb begin
        cnt_d = cnt_q;
        if (kind_e == K_MUL) begin
            cnt_d = MUL_CYCLES;
        end else if (kind_e == K_DIV) begin
            cnt_d = DIV_CYCLES;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall = data_stall || md_stall;
    assign pc_en = !stall;
    assign d_en  = !stall;
    assign e_clr = stall;

endmodule
`default_nettype wire
